// File: rtl/sipo_receiver.sv
// Serial-in, parallel-out receiver: assembles LSB-first words and offers them through a
// single-entry valid/ready holding register. Define SIPO_PARITY_EN to add a trailing even-parity bit.
module sipo_receiver #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             serial_in,
  input  logic             serial_valid,
  input  logic             frame_start,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  input  logic             data_ready,
  output logic             overrun,
  input  logic             overrun_clr,
  output logic             busy,
  output logic             parity_err
);

`ifdef SIPO_PARITY_EN
  localparam int unsigned FRAME = WIDTH + 1;
  localparam int unsigned SHW   = WIDTH;
`else
  // Without parity the last data bit is taken straight from serial_in, so only WIDTH-1 bits are stored.
  localparam int unsigned FRAME = WIDTH;
  localparam int unsigned SHW   = WIDTH - 1;
`endif
  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(FRAME - 1);

  typedef enum logic { IDLE, RECV }  rx_state_t;
  typedef enum logic { EMPTY, FULL } hold_state_t;

  rx_state_t        rx_state;
  hold_state_t      hold;
  logic [SHW-1:0]   sh;
  logic [SHW-1:0]   sh_shifted;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] word;
  logic             word_perr;
  logic             complete;
  logic             drain;

  always_comb begin
    sh_shifted = SHW'({serial_in, sh} >> 1);
    complete   = serial_valid && !frame_start && (rx_state == RECV) && (cnt == LAST);
    drain      = (hold == FULL) && data_ready;
`ifdef SIPO_PARITY_EN
    word       = sh;
    word_perr  = ^{serial_in, sh};
`else
    word       = {serial_in, sh};
    word_perr  = 1'b0;
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sh         <= '0;
      cnt        <= '0;
      rx_state   <= IDLE;
      hold       <= EMPTY;
      data_out   <= '0;
      data_valid <= 1'b0;
      overrun    <= 1'b0;
      busy       <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      if (serial_valid) begin
        if (frame_start) begin
          // Stale bits of a discarded partial word are flushed out before the new word completes.
          sh       <= sh_shifted;
          cnt      <= CW'(1);
          rx_state <= RECV;
          busy     <= 1'b1;
        end else if (complete) begin
          cnt      <= '0;
          rx_state <= IDLE;
          busy     <= 1'b0;
        end else begin
          sh       <= sh_shifted;
          cnt      <= cnt + CW'(1);
          rx_state <= RECV;
          busy     <= 1'b1;
        end
      end

      if (overrun_clr)
        overrun <= 1'b0;

      // A fresh overrun is assigned after the clear so that it takes priority.
      if (complete) begin
        if ((hold == EMPTY) || drain) begin
          data_out   <= word;
          parity_err <= word_perr;
          hold       <= FULL;
          data_valid <= 1'b1;
        end else begin
          overrun    <= 1'b1;
        end
      end else if (drain) begin
        hold       <= EMPTY;
        data_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/sipo_receiver.md
# sipo_receiver

Serial-in, parallel-out receiver: the receive-side counterpart of the team's LSB-first serializing shift register. It accepts one serial bit per qualified clock, assembles WIDTH-bit words LSB first, and presents each completed word on a valid/ready parallel port through a single-entry holding register. It reports overrun when a new word completes while the previous one is still unread. It sits between a serial link or serializer output and a word-oriented consumer.

## Interface
- WIDTH, 8: data word width in bits (≥2).
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- serial_in  input  1  serial data bit.
- serial_valid  input  1  serial_in is sampled on this clock edge.
- frame_start  input  1  qualified by serial_valid; the sampled bit is bit 0 of a new word.
- data_out  output  WIDTH  assembled word.
- data_valid  output  1  data_out holds an unread word.
- data_ready  input  1  consumer accepts data_out when data_valid=1.
- overrun  output  1  sticky; a completed word was dropped.
- overrun_clr  input  1  clears overrun.
- busy  output  1  partial word in progress (bit count ≠ 0).
- parity_err  output  1  parity flag for the word on data_out (see Configuration).

## Operation
- Shift register sh[WIDTH-1:0] and bit counter cnt (width $clog2(WIDTH+1)).
- Receive FSM, states IDLE (cnt=0) and RECV (0<cnt<FRAME). FRAME=WIDTH, or WIDTH+1 with parity.
- Accepted bit (serial_valid=1): sh <= {serial_in, sh[WIDTH-1:1]}, cnt <= cnt+1. After WIDTH data bits, bit 0 sits in sh[0].
- frame_start=1 with serial_valid=1: partial word discarded, cnt <= 1, and this bit becomes bit 0. Goes to RECV from either state. frame_start without serial_valid is ignored.
- Completion: an accepted bit that makes cnt reach FRAME. cnt <= 0, FSM returns to IDLE, and the word is offered to the holding register.
- Holding register states EMPTY and FULL, with data_valid = FULL.
  - Drain: data_valid & data_ready in a cycle, so the register becomes EMPTY at the next edge.
  - Completion while EMPTY, or while FULL and draining in the same cycle: data_out <= word and data_valid stays or goes 1. No overrun.
  - Completion while FULL and not draining: the new word is dropped, data_out is unchanged, and overrun <= 1.
- overrun clears only on overrun_clr=1 or reset. If overrun_clr and a new overrun occur in the same cycle, the set wins.
- data_out holds its value while data_valid=0. Consumers must ignore it.
- Reset (rst_n=0 at an edge, including mid-word or with FULL): sh=0, cnt=0, IDLE, EMPTY. Outputs reset to data_out=0, data_valid=0, overrun=0, busy=0, parity_err=0. Partial and held words are lost.

## Timing
- Latency: data_valid=1 and data_out are valid in the cycle after the edge that sampled the last frame bit.
- Throughput: back-to-back frames with serial_valid held high are lossless provided data_ready=1 in the cycle data_valid rises.
- busy is registered and equals (cnt≠0).
- No combinational path from any input to any output.
- serial_valid gaps of any length are allowed mid-word. They do not time out.

## Configuration
- SIPO_PARITY_EN defined:
  - FRAME=WIDTH+1. The last bit is an even-parity bit over the WIDTH data bits and is not shifted into sh.
  - parity_err is loaded together with data_out: 1 when the XOR of the data bits and the parity bit is 1.
  - A dropped word's parity result is discarded.
- SIPO_PARITY_EN undefined:
  - FRAME=WIDTH.
  - parity_err is constantly 0.

## Test plan
- WIDTH=8, data_ready=1. Send bits 1,0,1,0,0,1,0,1 (0xA5 LSB first) on consecutive cycles with frame_start on the first bit. Required: data_out=0xA5, and data_valid=1 for exactly one cycle, starting the cycle after the 8th bit's edge.
- Same word 0x3C with random 0–3 cycle serial_valid gaps between bits. Required: data_out=0x3C, and busy=1 from the first bit until completion.
- data_ready=0. Send 0x11 then 0x22. Required: data_out stays 0x11, overrun=1 after the second completion. Then data_ready=1 drains 0x11. overrun stays 1 until an overrun_clr pulse.
- data_valid=1 holding 0x55, and the next word 0xAA completes in the same cycle that data_ready=1. Required: data_out=0xAA, data_valid stays 1, overrun=0.
- Send 4 bits, then frame_start with a new 8-bit word 0xF0. Required: data_out=0xF0 with no stray word. Separately, assert rst_n=0 after 5 bits. Required: all outputs at 0, and the next full frame decodes correctly.
- SIPO_PARITY_EN defined: send 0x07 with parity 1. Required: data_out=0x07, parity_err=0. Send 0x07 with parity 0. Required: parity_err=1.
